// File: rtl/alu_pkg.sv
// Shared ALU op codes, legal-op check and arbiter state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add, sub, and, or, unsigned slt.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [2:0]  ALUControl,
  output logic [31:0] ALUResult
);

  always_comb begin
    ALUResult = 'x;
    case (ALUControl)
      ALU_ADD: ALUResult = SrcA + SrcB;
      ALU_SUB: ALUResult = SrcA - SrcB;
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_OR:  ALUResult = SrcA | SrcB;
      ALU_SLT: ALUResult = {31'd0, (SrcA < SrcB)};
      default: ALUResult = 'x;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU; a one-entry result slot is held per owner.
// Handshake: a transfer happens on an edge where valid && ready; valid never waits on ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid0,
  input  logic        ReqValid1,
  output logic        ReqReady0,
  output logic        ReqReady1,
  input  logic [31:0] SrcA0,
  input  logic [31:0] SrcA1,
  input  logic [31:0] SrcB0,
  input  logic [31:0] SrcB1,
  input  logic [2:0]  ALUControl0,
  input  logic [2:0]  ALUControl1,
  output logic        RespValid0,
  output logic        RespValid1,
  input  logic        RespReady0,
  input  logic        RespReady1,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        Err,
  output logic [1:0]  DbgState
);

  arb_state_t  r_state;
  logic        r_owner;
  logic        r_last;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_err;

  logic        w_slot_free;
  logic        w_grant0;
  logic        w_grant1;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [2:0]  w_op;
  logic [31:0] w_alu_result;
  logic        w_legal;

  assign w_slot_free = (r_state == ST_IDLE) || (r_owner ? RespReady1 : RespReady0);

  // Port 0 wins unless port 1 is alone or round-robin says port 0 went last.
  assign w_grant0 = !reset && w_slot_free && ReqValid0 &&
                    (!ReqValid1 || !RR_EN || r_last);
  assign w_grant1 = !reset && w_slot_free && ReqValid1 && !w_grant0;

  assign w_src_a = w_grant1 ? SrcA1 : SrcA0;
  assign w_src_b = w_grant1 ? SrcB1 : SrcB0;
  assign w_op    = w_grant1 ? ALUControl1 : ALUControl0;
  assign w_legal = is_legal_op(w_op);

  alu u_alu (
    .SrcA       (w_src_a),
    .SrcB       (w_src_b),
    .ALUControl (w_op),
    .ALUResult  (w_alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_result <= 32'd0;
      r_zero   <= 1'b1;
      r_err    <= 1'b0;
    end else if (w_grant0 || w_grant1) begin
      r_state  <= ST_HOLD;
      r_owner  <= w_grant1;
      r_last   <= w_grant1;
      // Undefined ops never let the ALU's unknown result reach the register.
      r_result <= w_legal ? w_alu_result : 32'd0;
      r_zero   <= w_legal ? (w_alu_result == 32'd0) : 1'b1;
      r_err    <= !w_legal;
    end else if (r_state == ST_HOLD && w_slot_free) begin
      r_state  <= ST_IDLE;
    end
  end

  assign ReqReady0  = w_grant0;
  assign ReqReady1  = w_grant1;
  assign RespValid0 = (r_state == ST_HOLD) && !r_owner;
  assign RespValid1 = (r_state == ST_HOLD) && r_owner;
  assign ALUResult  = r_result;
  assign Zero       = r_zero;
  assign Err        = r_err;
  assign DbgState   = {r_owner, r_state == ST_HOLD};

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority one share inputs.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid0, ReqValid1, RespReady0, RespReady1;
  logic [31:0] SrcA0, SrcA1, SrcB0, SrcB1;
  logic [2:0]  ALUControl0, ALUControl1;

  logic        ReqReady0, ReqReady1, RespValid0, RespValid1, Zero, Err;
  logic [31:0] ALUResult;
  logic [1:0]  DbgState;

  logic        f_ReqReady0, f_ReqReady1, f_RespValid0, f_RespValid1, f_Zero, f_Err;
  logic [31:0] f_ALUResult;
  logic [1:0]  f_DbgState;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .ReqValid0(ReqValid0), .ReqValid1(ReqValid1),
    .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
    .SrcA0(SrcA0), .SrcA1(SrcA1), .SrcB0(SrcB0), .SrcB1(SrcB1),
    .ALUControl0(ALUControl0), .ALUControl1(ALUControl1),
    .RespValid0(RespValid0), .RespValid1(RespValid1),
    .RespReady0(RespReady0), .RespReady1(RespReady1),
    .ALUResult(ALUResult), .Zero(Zero), .Err(Err), .DbgState(DbgState)
  );

  alu_arbiter #(.RR_EN(1'b0)) dut_fixed (
    .clk(clk), .reset(reset),
    .ReqValid0(ReqValid0), .ReqValid1(ReqValid1),
    .ReqReady0(f_ReqReady0), .ReqReady1(f_ReqReady1),
    .SrcA0(SrcA0), .SrcA1(SrcA1), .SrcB0(SrcB0), .SrcB1(SrcB1),
    .ALUControl0(ALUControl0), .ALUControl1(ALUControl1),
    .RespValid0(f_RespValid0), .RespValid1(f_RespValid1),
    .RespReady0(RespReady0), .RespReady1(RespReady1),
    .ALUResult(f_ALUResult), .Zero(f_Zero), .Err(f_Err), .DbgState(f_DbgState)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    RespReady0 = 1'b0; RespReady1 = 1'b0;
    SrcA0 = '0; SrcA1 = '0; SrcB0 = '0; SrcB1 = '0;
    ALUControl0 = 3'b000; ALUControl1 = 3'b000;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    #1;
    n_checks++;
    if ({ReqReady0, ReqReady1} !== 2'b00) begin
      n_fail++; $display("FAIL rst_reqready: got %b exp 00", {ReqReady0, ReqReady1});
    end
    tick();
    reset = 1'b0; ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    #1;
    n_checks++;
    if ({RespValid0, RespValid1} !== 2'b00) begin
      n_fail++; $display("FAIL rst_respvalid: got %b exp 00", {RespValid0, RespValid1});
    end
    n_checks++;
    if (ALUResult !== 32'd0 || Zero !== 1'b1 || Err !== 1'b0) begin
      n_fail++; $display("FAIL rst_outputs: got res=%h z=%b e=%b exp 0/1/0", ALUResult, Zero, Err);
    end
  endtask

  task automatic test_add();
    SrcA0 = 32'd5; SrcB0 = 32'd7; ALUControl0 = 3'b000; ReqValid0 = 1'b1;
    #1;
    n_checks++;
    if ({ReqReady0, ReqReady1} !== 2'b10) begin
      n_fail++; $display("FAIL add_grant: got %b exp 10", {ReqReady0, ReqReady1});
    end
    tick();
    ReqValid0 = 1'b0;
    #1;
    n_checks++;
    if ({RespValid0, RespValid1} !== 2'b10 || ALUResult !== 32'd12 || Zero !== 1'b0 || Err !== 1'b0) begin
      n_fail++; $display("FAIL add_result: got rv=%b res=%0d z=%b e=%b exp rv=10 res=12 z=0 e=0",
                         {RespValid0, RespValid1}, ALUResult, Zero, Err);
    end
    RespReady0 = 1'b1;
    tick();
    RespReady0 = 1'b0;
    n_checks++;
    if ({RespValid0, RespValid1} !== 2'b00) begin
      n_fail++; $display("FAIL add_consume: got %b exp 00", {RespValid0, RespValid1});
    end
  endtask

  task automatic test_arbitration();
    logic exp1;
    do_reset();
    SrcA0 = 32'd1;  SrcB0 = 32'd2; ALUControl0 = 3'b000;
    SrcA1 = 32'd10; SrcB1 = 32'd4; ALUControl1 = 3'b001;
    ReqValid0 = 1'b1; ReqValid1 = 1'b1; RespReady0 = 1'b1; RespReady1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp1 = (i % 2 == 1);
      #1;
      n_checks++;
      if ({ReqReady0, ReqReady1} !== {!exp1, exp1}) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b exp %b", i, {ReqReady0, ReqReady1}, {!exp1, exp1});
      end
      n_checks++;
      if ({f_ReqReady0, f_ReqReady1} !== 2'b10) begin
        n_fail++; $display("FAIL fixed_grant%0d: got %b exp 10", i, {f_ReqReady0, f_ReqReady1});
      end
      tick();
      n_checks++;
      if ({RespValid0, RespValid1} !== {!exp1, exp1} || ALUResult !== (exp1 ? 32'd6 : 32'd3)) begin
        n_fail++; $display("FAIL rr_result%0d: got rv=%b res=%0d exp rv=%b res=%0d", i,
                           {RespValid0, RespValid1}, ALUResult, {!exp1, exp1}, exp1 ? 6 : 3);
      end
    end
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    tick();
    RespReady0 = 1'b0; RespReady1 = 1'b0;
  endtask

  task automatic test_hold_stable();
    do_reset();
    SrcA1 = 32'd9; SrcB1 = 32'd9; ALUControl1 = 3'b001; ReqValid1 = 1'b1;
    tick();
    ReqValid1 = 1'b0;
    SrcA0 = 32'd20; SrcB0 = 32'd22; ALUControl0 = 3'b000; ReqValid0 = 1'b1;
    RespReady0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ReqReady0 !== 1'b0) begin
        n_fail++; $display("FAIL hold_block%0d: got ReqReady0=%b exp 0", i, ReqReady0);
      end
      n_checks++;
      if ({RespValid0, RespValid1} !== 2'b01 || ALUResult !== 32'd0 || Zero !== 1'b1 || Err !== 1'b0) begin
        n_fail++; $display("FAIL hold_stable%0d: got rv=%b res=%0d z=%b e=%b exp rv=01 res=0 z=1 e=0",
                           i, {RespValid0, RespValid1}, ALUResult, Zero, Err);
      end
      tick();
    end
    RespReady1 = 1'b1;
    #1;
    n_checks++;
    if ({ReqReady0, ReqReady1} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_grant: got %b exp 10", {ReqReady0, ReqReady1});
    end
    tick();
    ReqValid0 = 1'b0; RespReady1 = 1'b0;
    #1;
    n_checks++;
    if ({RespValid0, RespValid1} !== 2'b10 || ALUResult !== 32'd42 || Zero !== 1'b0) begin
      n_fail++; $display("FAIL b2b_result: got rv=%b res=%0d z=%b exp rv=10 res=42 z=0",
                         {RespValid0, RespValid1}, ALUResult, Zero);
    end
    tick();
    RespReady0 = 1'b0;
  endtask

  task automatic test_undefined_op();
    do_reset();
    SrcA0 = 32'd3; SrcB0 = 32'd4; ALUControl0 = 3'b110; ReqValid0 = 1'b1;
    tick();
    ReqValid0 = 1'b0;
    #1;
    n_checks++;
    if (RespValid0 !== 1'b1 || ALUResult !== 32'd0 || Zero !== 1'b1 || Err !== 1'b1) begin
      n_fail++; $display("FAIL undef_result: got rv=%b res=%h z=%b e=%b exp rv=1 res=0 z=1 e=1",
                         RespValid0, ALUResult, Zero, Err);
    end
    n_checks++;
    if ($isunknown({ReqReady0, ReqReady1, RespValid0, RespValid1, ALUResult, Zero, Err})) begin
      n_fail++; $display("FAIL undef_no_x: got unknown bits on outputs exp none");
    end
    RespReady0 = 1'b1;
    tick();
    RespReady0 = 1'b0;
  endtask

  task automatic test_boundary();
    logic [2:0]  ops  [6] = '{3'b101, 3'b101, 3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] a_v  [6] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'hF0, 32'hF0};
    logic [31:0] b_v  [6] = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h0F, 32'h3C};
    logic [31:0] exp_v[6] = '{32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFF, 32'h30};
    do_reset();
    RespReady0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      SrcA0 = a_v[i]; SrcB0 = b_v[i]; ALUControl0 = ops[i]; ReqValid0 = 1'b1;
      tick();
      n_checks++;
      if (RespValid0 !== 1'b1 || ALUResult !== exp_v[i] || Zero !== (exp_v[i] == 32'd0) || Err !== 1'b0) begin
        n_fail++; $display("FAIL boundary%0d: got rv=%b res=%h z=%b e=%b exp rv=1 res=%h z=%b e=0",
                           i, RespValid0, ALUResult, Zero, Err, exp_v[i], exp_v[i] == 32'd0);
      end
    end
    ReqValid0 = 1'b0;
    tick();
    RespReady0 = 1'b0;
  endtask

  task automatic test_reset_priority();
    do_reset();
    SrcA0 = 32'd1; SrcB0 = 32'd1; ALUControl0 = 3'b000; ReqValid0 = 1'b1;
    tick();
    ReqValid0 = 1'b0;
    SrcA1 = 32'd7; SrcB1 = 32'd1; ALUControl1 = 3'b000; ReqValid1 = 1'b1;
    RespReady0 = 1'b1; reset = 1'b1;
    #1;
    n_checks++;
    if ({ReqReady0, ReqReady1} !== 2'b00) begin
      n_fail++; $display("FAIL rstprio_ready: got %b exp 00", {ReqReady0, ReqReady1});
    end
    tick();
    reset = 1'b0; ReqValid1 = 1'b0; RespReady0 = 1'b0;
    #1;
    n_checks++;
    if ({RespValid0, RespValid1} !== 2'b00 || ALUResult !== 32'd0 || Zero !== 1'b1 || Err !== 1'b0) begin
      n_fail++; $display("FAIL rstprio_state: got rv=%b res=%0d z=%b e=%b exp rv=00 res=0 z=1 e=0",
                         {RespValid0, RespValid1}, ALUResult, Zero, Err);
    end
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    #1;
    n_checks++;
    if ({ReqReady0, ReqReady1} !== 2'b10) begin
      n_fail++; $display("FAIL rstprio_tie: got %b exp 10", {ReqReady0, ReqReady1});
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_add();
    test_arbitration();
    test_hold_stable();
    test_undefined_op();
    test_boundary();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority to port 0.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ReqValid0/ReqValid1  input  1 each  requester x presents an operation.
REQ-005 ReqReady0/ReqReady1  output  1 each  requester x's operation is accepted this cycle.
REQ-006 SrcA0/SrcA1, SrcB0/SrcB1  input  32 each  operands from requester x.
REQ-007 ALUControl0/ALUControl1  input  3 each  op code from requester x: 000 add, 001 sub, 101 slt, 011 or, 010 and.
REQ-008 RespValid0/RespValid1  output  1 each  result held for requester x.
REQ-009 RespReady0/RespReady1  input  1 each  requester x consumes its result.
REQ-010 ALUResult  output  32  registered result, shared by both response ports.
REQ-011 Zero  output  1  registered; equals (ALUResult == 0).
REQ-012 Err  output  1  registered; held result came from an undefined op code.

Function
REQ-013 Exactly one shared ALU instance is present; the arbiter drives its SrcA, SrcB and ALUControl inputs from the granted port, else from port 0.
REQ-014 State: IDLE (no result held) or HOLD (result held for Owner ∈ {0,1}).
REQ-015 Slot free = IDLE, or HOLD with RespReady of the current Owner high.
REQ-016 Grant is combinational: when the slot is free, the arbiter raises ReqReady for exactly one requester with ReqValid high; it never raises both.
REQ-017 With RR_EN=1 and both ReqValid high, the requester not granted last wins; with a single valid requester, that requester wins.
REQ-018 With RR_EN=0, port 0 always wins a tie.
REQ-019 On a grant edge, the arbiter latches ALUResult, Zero, Err and Owner, enters HOLD, and updates the last-grant pointer.
REQ-020 Latency is 1 cycle: a request accepted at edge N makes RespValid of the owner high after edge N.
REQ-021 In HOLD, only RespValid of the Owner is high; ALUResult, Zero and Err stay stable until consumed.
REQ-022 When the Owner's RespReady is high with no new grant, the arbiter returns to IDLE and RespValid drops after the edge.
REQ-023 Consume and new grant in the same cycle give back-to-back service: the arbiter stays in HOLD with the new data and Owner.
REQ-024 RespReady of the non-owner is ignored, and RespReady in IDLE is ignored.
REQ-025 Undefined ALUControl (100, 110, 111) gives a latched ALUResult of 0, Zero=1 and Err=1; the X output of the ALU is never registered.
REQ-026 slt is unsigned compare (SrcA < SrcB); add and sub wrap modulo 2^32.
REQ-027 A requester may drop ReqValid before it is granted; nothing is latched for it.

Reset
REQ-028 reset while clk rises forces: IDLE, RespValid0=RespValid1=0, ALUResult=0, Zero=1, Err=0, Owner=0, last-grant=1 (so port 0 wins the first tie).
REQ-029 Reset takes priority over any grant or consume in the same cycle; a held result is discarded.
REQ-030 ReqReady0 and ReqReady1 are 0 in any cycle with reset high.

Structure
REQ-031 The op-code constants (ADD, SUB, SLT, OR, AND) and a legal-op check function belong in a shared package, alu_pkg.
REQ-032 The only sub-module is the existing alu, instantiated once; the arbiter logic stays flat in alu_arbiter.

Verification
REQ-033 After reset, port 0 requests add 5+7 -> ReqReady0=1 that cycle; next cycle RespValid0=1, ALUResult=12, Zero=0, Err=0.
REQ-034 Both ports valid for 4 cycles with RespReady held 1 and RR_EN=1 -> grants alternate 0,1,0,1; with RR_EN=0 -> 0,0,0,0.
REQ-035 Port 1 requests sub 9-9 with RespReady1=0 for 3 cycles -> ALUResult=0, Zero=1 held stable; ReqReady0=0 throughout despite ReqValid0=1.
REQ-036 Port 0 requests op 110 -> ALUResult=0, Zero=1, Err=1, no X on any output.
REQ-037 Port 0 requests slt 0xFFFFFFFF<1 -> ALUResult=0; add 0xFFFFFFFF+1 -> ALUResult=0, Zero=1.
REQ-038 reset asserted during HOLD with a simultaneous new grant -> after the edge: IDLE, RespValid0/1=0, ALUResult=0; a following tie grants port 0.
